// File: rtl/stream_fifo_pkg.sv
// Shared constants for the stream FIFO: default geometry and loss-counter sizing.
package stream_fifo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH_LG2 = 2;

    localparam int                DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

endpackage

// File: rtl/stream_fifo_mem.sv
// Storage array for the stream FIFO: one synchronous write port, one asynchronous read port.
module stream_fifo_mem
    import stream_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH_LG2 = DEF_DEPTH_LG2
) (
    input  logic                 clk50,
    input  logic                 we,
    input  logic [DEPTH_LG2-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [DEPTH_LG2-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LG2];

    always_ff @(posedge clk50) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Level-tracked stream FIFO with drop-new or overwrite-oldest behaviour on full and a sticky loss counter.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH_LG2 = DEF_DEPTH_LG2,
    parameter int OVERWRITE = 0,
    parameter int AFULL_LVL = (2**DEPTH_LG2) - 1
) (
    input  logic                 clk50,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DEPTH_LG2:0]   level,
    output logic                 almost_full,
    output logic                 overflow,
    output logic [DROP_W-1:0]    drop_cnt,
    input  logic                 clr_ovf
);

    localparam bit               OVW     = (OVERWRITE != 0);
    localparam logic [DEPTH_LG2:0] DEPTH_L = {1'b1, {DEPTH_LG2{1'b0}}};
    localparam logic [DEPTH_LG2:0] AFULL_L = AFULL_LVL[DEPTH_LG2:0];

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + 1'b1;
    endfunction

    logic [DEPTH_LG2-1:0] head;
    logic [DEPTH_LG2-1:0] tail;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 loss;

    // Full/empty come from the level register so that wrapped pointers never alias.
    assign full        = (level == DEPTH_L);
    assign out_valid   = (level != '0);
    assign in_ready    = !full || OVW;
    assign almost_full = (level >= AFULL_L);

    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop || OVW);
    assign loss = in_valid && full && !pop;

    always_ff @(posedge clk50) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            // An overwrite on full retires the oldest entry, so head moves with tail.
            if (pop || (push && full)) head <= head + 1'b1;
            if (push && !pop && !full)  level <= level + 1'b1;
            else if (pop && !push)      level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            overflow <= loss;
            drop_cnt <= {{(DROP_W-1){1'b0}}, loss};
        end else if (loss) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    stream_fifo_mem #(
        .DATA_W    (DATA_W),
        .DEPTH_LG2 (DEPTH_LG2)
    ) u_mem (
        .clk50 (clk50),
        .we    (push && !rst),
        .waddr (tail),
        .wdata (in_data),
        .raddr (head),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: a drop-new and an overwrite-oldest instance share one stimulus stream.
module tb_stream_fifo;

    logic       clk50 = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_ovf = 1'b0;

    logic       in_ready0, out_valid0, almost_full0, overflow0;
    logic [7:0] out_data0, drop_cnt0;
    logic [2:0] level0;
    logic       in_ready1, out_valid1, almost_full1, overflow1;
    logic [7:0] out_data1, drop_cnt1;
    logic [2:0] level1;

    int checks = 0;
    int passed = 0;

    always #5 clk50 = ~clk50;

    stream_fifo #(.DATA_W(8), .DEPTH_LG2(2), .OVERWRITE(0), .AFULL_LVL(3)) dut0 (
        .clk50(clk50), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready), .level(level0),
        .almost_full(almost_full0), .overflow(overflow0), .drop_cnt(drop_cnt0), .clr_ovf(clr_ovf)
    );

    stream_fifo #(.DATA_W(8), .DEPTH_LG2(2), .OVERWRITE(1), .AFULL_LVL(3)) dut1 (
        .clk50(clk50), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready), .level(level1),
        .almost_full(almost_full1), .overflow(overflow1), .drop_cnt(drop_cnt1), .clr_ovf(clr_ovf)
    );

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        in_data = v; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (level0 !== 3'd0) $display("FAIL rst_level got=%0d exp=0", level0); else passed++;
        checks++; if (out_valid0 !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid0); else passed++;
        checks++; if (almost_full0 !== 1'b0) $display("FAIL rst_afull got=%b exp=0", almost_full0); else passed++;
        checks++; if (in_ready0 !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready0); else passed++;
        checks++; if (overflow0 !== 1'b0) $display("FAIL rst_overflow got=%b exp=0", overflow0); else passed++;
        checks++; if (drop_cnt0 !== 8'd0) $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt0); else passed++;
        checks++; if (in_ready1 !== 1'b1) $display("FAIL rst_in_ready_ovw got=%b exp=1", in_ready1); else passed++;
    endtask

    task automatic test_order();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        logic [2:0] lvl_after [3] = '{3'd2, 3'd1, 3'd0};
        do_reset();
        push(8'h11);
        checks++; if (out_valid0 !== 1'b1) $display("FAIL order_valid1 got=%b exp=1", out_valid0); else passed++;
        checks++; if (out_data0 !== 8'h11) $display("FAIL order_head1 got=%h exp=11", out_data0); else passed++;
        checks++; if (level0 !== 3'd1 || almost_full0 !== 1'b0) $display("FAIL order_lvl1 got=%0d/%b exp=1/0", level0, almost_full0); else passed++;
        push(8'h22);
        checks++; if (level0 !== 3'd2 || almost_full0 !== 1'b0) $display("FAIL order_lvl2 got=%0d/%b exp=2/0", level0, almost_full0); else passed++;
        push(8'h33);
        checks++; if (level0 !== 3'd3 || almost_full0 !== 1'b1) $display("FAIL order_lvl3 got=%0d/%b exp=3/1", level0, almost_full0); else passed++;
        checks++; if (in_ready0 !== 1'b1) $display("FAIL order_ready3 got=%b exp=1", in_ready0); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_data0 !== vals[i]) $display("FAIL order_pop%0d got=%h exp=%h", i, out_data0, vals[i]); else passed++;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++; if (level0 !== lvl_after[i] || almost_full0 !== 1'b0) $display("FAIL order_poplvl%0d got=%0d/%b exp=%0d/0", i, level0, almost_full0, lvl_after[i]); else passed++;
        end
        checks++; if (out_valid0 !== 1'b0) $display("FAIL order_empty got=%b exp=0", out_valid0); else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (level0 !== 3'd0) $display("FAIL empty_pop_level got=%0d exp=0", level0); else passed++;
        push(8'h44);
        checks++; if (out_data0 !== 8'h44 || level0 !== 3'd1) $display("FAIL empty_pop_head got=%h/%0d exp=44/1", out_data0, level0); else passed++;
    endtask

    task automatic test_loss();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push(8'(i + 1));
            if (i == 3) begin
                checks++; if (level0 !== 3'd4 || overflow0 !== 1'b0) $display("FAIL loss_fill got=%0d/%b exp=4/0", level0, overflow0); else passed++;
            end
        end
        checks++; if (level0 !== 3'd4) $display("FAIL drop_level got=%0d exp=4", level0); else passed++;
        checks++; if (overflow0 !== 1'b1 || drop_cnt0 !== 8'd2) $display("FAIL drop_count got=%b/%0d exp=1/2", overflow0, drop_cnt0); else passed++;
        checks++; if (in_ready0 !== 1'b0) $display("FAIL drop_ready got=%b exp=0", in_ready0); else passed++;
        checks++; if (level1 !== 3'd4 || drop_cnt1 !== 8'd2 || overflow1 !== 1'b1) $display("FAIL ovw_count got=%0d/%0d/%b exp=4/2/1", level1, drop_cnt1, overflow1); else passed++;
        checks++; if (in_ready1 !== 1'b1) $display("FAIL ovw_ready got=%b exp=1", in_ready1); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_data0 !== 8'(i + 1)) $display("FAIL drop_pop%0d got=%h exp=%h", i, out_data0, 8'(i + 1)); else passed++;
            checks++; if (out_data1 !== 8'(i + 3)) $display("FAIL ovw_pop%0d got=%h exp=%h", i, out_data1, 8'(i + 3)); else passed++;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        checks++; if (level0 !== 3'd0 || level1 !== 3'd0) $display("FAIL loss_drain got=%0d/%0d exp=0/0", level0, level1); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4] = '{8'h02, 8'h03, 8'h04, 8'hAA};
        do_reset();
        for (int i = 0; i < 4; i++) push(8'(i + 1));
        in_data = 8'hAA; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (level0 !== 3'd4) $display("FAIL b2b_level got=%0d exp=4", level0); else passed++;
        checks++; if (overflow0 !== 1'b0 || drop_cnt0 !== 8'd0 || drop_cnt1 !== 8'd0) $display("FAIL b2b_noloss got=%b/%0d/%0d exp=0/0/0", overflow0, drop_cnt0, drop_cnt1); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_data0 !== vals[i]) $display("FAIL b2b_pop%0d got=%h exp=%h", i, out_data0, vals[i]); else passed++;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_clr_sat();
        do_reset();
        for (int i = 0; i < 4; i++) push(8'(i + 1));
        in_valid = 1'b1;
        tick();
        tick();
        checks++; if (drop_cnt0 !== 8'd2) $display("FAIL clr_pre got=%0d exp=2", drop_cnt0); else passed++;
        clr_ovf = 1'b1;
        tick();
        checks++; if (overflow0 !== 1'b1 || drop_cnt0 !== 8'd1) $display("FAIL clr_coincident got=%b/%0d exp=1/1", overflow0, drop_cnt0); else passed++;
        in_valid = 1'b0;
        tick();
        checks++; if (overflow0 !== 1'b0 || drop_cnt0 !== 8'd0) $display("FAIL clr_plain got=%b/%0d exp=0/0", overflow0, drop_cnt0); else passed++;
        clr_ovf = 1'b0;
        in_valid = 1'b1;
        repeat (254) tick();
        checks++; if (drop_cnt0 !== 8'd254) $display("FAIL sat_254 got=%0d exp=254", drop_cnt0); else passed++;
        repeat (46) tick();
        in_valid = 1'b0;
        checks++; if (drop_cnt0 !== 8'd255 || overflow0 !== 1'b1) $display("FAIL sat_255 got=%0d/%b exp=255/1", drop_cnt0, overflow0); else passed++;
        checks++; if (drop_cnt1 !== 8'd255 || level1 !== 3'd4) $display("FAIL sat_ovw got=%0d/%0d exp=255/4", drop_cnt1, level1); else passed++;
        checks++; if (level0 !== 3'd4 || out_data0 !== 8'h01) $display("FAIL sat_storage got=%0d/%h exp=4/01", level0, out_data0); else passed++;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow0 !== 1'b0 || drop_cnt0 !== 8'd0) $display("FAIL sat_clear got=%b/%0d exp=0/0", overflow0, drop_cnt0); else passed++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        push(8'h01);
        push(8'h02);
        checks++; if (level0 !== 3'd2) $display("FAIL midrst_pre got=%0d exp=2", level0); else passed++;
        in_data = 8'h77; in_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (level0 !== 3'd0 || out_valid0 !== 1'b0) $display("FAIL midrst_clear got=%0d/%b exp=0/0", level0, out_valid0); else passed++;
        push(8'h5A);
        checks++; if (out_valid0 !== 1'b1 || out_data0 !== 8'h5A || level0 !== 3'd1) $display("FAIL midrst_push got=%b/%h/%0d exp=1/5a/1", out_valid0, out_data0, level0); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_order();
        test_loss();
        test_back_to_back();
        test_clr_sat();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload width in bits.
REQ-002 SHALL have parameter DEPTH_LG2, default 2: log2 of entry count; DEPTH = 2**DEPTH_LG2, minimum 1.
REQ-003 SHALL have parameter OVERWRITE, default 0: 0 = drop new on full; 1 = overwrite oldest on full.
REQ-004 SHALL have parameter AFULL_LVL, default DEPTH-1: almost-full threshold, 1..DEPTH.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk50  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_data  in  DATA_W  write payload.
REQ-009 in_valid  in  1  write request; may be a single-cycle pulse from a source that cannot stall.
REQ-010 in_ready  out  1  advisory: 1 when not full, or always 1 if OVERWRITE=1.
REQ-011 out_data  out  DATA_W  oldest entry.
REQ-012 out_valid  out  1  FIFO non-empty.
REQ-013 out_ready  in  1  consumer accepts out_data.
REQ-014 level  out  DEPTH_LG2+1  current entry count, 0..DEPTH.
REQ-015 almost_full  out  1  level >= AFULL_LVL.
REQ-016 overflow  out  1  sticky loss flag.
REQ-017 drop_cnt  out  8  saturating count of lost entries.
REQ-018 clr_ovf  in  1  clears overflow and drop_cnt.

Function
REQ-019 pop SHALL be out_valid && out_ready; push SHALL be in_valid && (!full || pop || OVERWRITE).
REQ-020 A push SHALL write mem[tail] and advance tail modulo DEPTH; a pop SHALL advance head modulo DEPTH.
REQ-021 Pointers SHALL wrap silently; full/empty SHALL be derived from level, never from pointer equality alone.
REQ-022 out_valid SHALL assert in the cycle after the edge that pushes into an empty FIFO; there is no same-cycle fall-through.
REQ-023 out_data SHALL equal mem[head] whenever out_valid=1; it is don't-care when out_valid=0.
REQ-024 On push and pop in the same cycle, level SHALL be unchanged, including when full.
REQ-025 When empty, an asserted out_ready SHALL be ignored: no pop and no pointer change.
REQ-026 With OVERWRITE=0, full and in_valid without pop: the entry SHALL be discarded, storage unchanged, and a loss event recorded.
REQ-027 With OVERWRITE=1, full and in_valid without pop: the write SHALL occur, head and tail SHALL both advance, level SHALL stay DEPTH, and a loss event recorded.
REQ-028 A loss event SHALL set overflow and increment drop_cnt, saturating at 255.
REQ-029 clr_ovf SHALL zero overflow and drop_cnt; on a coincident loss event, overflow SHALL be 1 and drop_cnt SHALL be 1.
REQ-030 level, almost_full and in_ready SHALL be registered or derived only from registered state, with no combinational path from in_valid or out_ready.

Reset
REQ-031 rst SHALL zero head, tail, level, overflow and drop_cnt.
REQ-032 After reset, out_valid=0, almost_full=0 (AFULL_LVL >= 1), and in_ready=1.
REQ-033 Memory contents SHALL NOT require reset.
REQ-034 rst asserted mid-operation SHALL discard all entries at that edge and override any push or pop.

Structure
REQ-035 A shared package SHALL hold the default DATA_W and DEPTH_LG2 constants and the drop_cnt width and saturation value.
REQ-036 One sub-module is natural: stream_fifo_mem, a register array with one write port and one asynchronous read port, no reset.

Verification (DATA_W=8, DEPTH_LG2=2, AFULL_LVL=3)
REQ-037 Push 0x11, 0x22, 0x33 with out_ready=0, then pop 3 -> out_data 0x11, 0x22, 0x33 in order; level 3->0; almost_full high only at level 3.
REQ-038 OVERWRITE=0: push 0x01..0x06, no pops -> level 4, overflow=1, drop_cnt=2; pops return 0x01..0x04.
REQ-039 OVERWRITE=1: push 0x01..0x06, no pops -> level 4, drop_cnt=2; pops return 0x03..0x06.
REQ-040 Fill to 4, then push 0xAA with out_ready=1 in the same cycle -> no loss, level 4; after 4 pops, the last value is 0xAA.
REQ-041 Loss event coincident with clr_ovf -> overflow=1, drop_cnt=1; 300 losses -> drop_cnt=255.
REQ-042 rst pulsed at level 2 during a push -> next cycle level=0, out_valid=0; a following push of 0x5A is read back as 0x5A.
